// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types and constants for the registered request arbiter.
// Holds policy codes, FSM state encoding and an index-width helper.
package rr_priority_arbiter_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_arbiter_rr_pick.sv
// Combinational winner picker: rotate by last, highest-index encode, un-rotate.
// Ports: cand (candidates), last (pointer), mode (1=rr), win (index), found.
module rr_pick
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] last,
    input  logic             mode,
    output logic [IDX_W-1:0] win,
    output logic             found
);

    localparam logic [IDX_W:0] NW = (IDX_W+1)'(N);

    logic [IDX_W-1:0] sh;
    logic [N-1:0]     rot;
    logic [IDX_W:0]   rsum;
    logic [IDX_W-1:0] pos;
    logic [IDX_W:0]   wsum;

    // rot[j] = cand[(j+sh) mod N]; the top of rot is requester last-1,
    // so the last-served requester lands at the bottom (lowest priority).
    always_comb begin
        sh    = mode ? last : '0;
        rot   = '0;
        rsum  = '0;
        pos   = '0;
        wsum  = '0;
        found = |cand;
        for (int j = 0; j < N; j++) begin
            rsum = (IDX_W+1)'(j) + {1'b0, sh};
            if (rsum >= NW) rsum = rsum - NW;
            rot[j] = cand[rsum[IDX_W-1:0]];
        end
        for (int j = 0; j < N; j++) begin
            if (rot[j]) pos = IDX_W'(j);
        end
        wsum = {1'b0, pos} + {1'b0, sh};
        if (wsum >= NW) wsum = wsum - NW;
        win = wsum[IDX_W-1:0];
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with fixed or round-robin policy and grant locking.
// Ports: req/en/done in; gnt (one-hot), gnt_idx, gnt_vld registered; any_req comb.
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             any_req
);

    localparam logic RR_EN = (MODE == MODE_RR);

    state_t           state, state_n;
    logic [IDX_W-1:0] last, last_n;
    logic [N-1:0]     gnt_n;
    logic [IDX_W-1:0] idx_n;
    logic             vld_n;

    logic [N-1:0]     cand;
    logic [IDX_W-1:0] pick_last;
    logic [IDX_W-1:0] win;
    logic             found;
    logic             rel;

    assign any_req = |req;

    // While busy the holder is excluded and the pointer the pick sees is
    // the holder itself, i.e. the value last takes on release.
    assign cand      = (state == ST_BUSY) ? (req & ~gnt) : req;
    assign pick_last = (state == ST_BUSY) ? gnt_idx : last;
    assign rel       = done | ~req[gnt_idx];

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .cand  (cand),
        .last  (pick_last),
        .mode  (RR_EN),
        .win   (win),
        .found (found)
    );

    always_comb begin
        state_n = state;
        last_n  = last;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        vld_n   = gnt_vld;
        unique case (state)
            ST_IDLE: begin
                gnt_n = '0;
                idx_n = '0;
                vld_n = 1'b0;
                if (en && found) begin
                    gnt_n[win] = 1'b1;
                    idx_n      = win;
                    vld_n      = 1'b1;
                    state_n    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rel) begin
                    last_n = gnt_idx;
                    gnt_n  = '0;
                    idx_n  = '0;
                    vld_n  = 1'b0;
                    if (en && found) begin
                        gnt_n[win] = 1'b1;
                        idx_n      = win;
                        vld_n      = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
                idx_n   = '0;
                vld_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            last    <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            gnt     <= gnt_n;
            gnt_idx <= idx_n;
            gnt_vld <= vld_n;
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench: fixed and round-robin instances share stimulus,
// each compared to a behavioural holder/pointer model.
module tb_rr_priority_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int VW = N + IW + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          done;
    logic [N-1:0]  req;

    logic [N-1:0]  gnt0, gnt1;
    logic [IW-1:0] idx0, idx1;
    logic          vld0, vld1, any0, any1;

    always #5 clk = ~clk;

    rr_priority_arbiter #(.N(N), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .en(en), .done(done),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_vld(vld0), .any_req(any0)
    );

    rr_priority_arbiter #(.N(N), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .en(en), .done(done),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_vld(vld1), .any_req(any1)
    );

    logic [VW-1:0] obs [2];
    assign obs[0] = {gnt0, idx0, vld0, any0};
    assign obs[1] = {gnt1, idx1, vld1, any1};

    int vectors     = 0;
    int miscompares = 0;
    int m_hold [2];
    int m_last [2];

    // m=0 fixed: highest set index. m=1 rr: scan last-1, last-2, ... wrapping.
    function automatic int model_pick(int m, logic [N-1:0] c, int lst);
        int w;
        w = -1;
        if (m == 0) begin
            for (int i = 0; i < N; i++) if (c[i]) w = i;
        end else begin
            for (int k = N; k >= 1; k--) begin
                int i;
                i = (lst - k + N) % N;
                if (c[i]) w = i;
            end
        end
        return w;
    endfunction

    function automatic logic [VW-1:0] expv(int m);
        logic [N-1:0]  g;
        logic [IW-1:0] ix;
        logic          v;
        g  = '0;
        ix = '0;
        v  = 1'b0;
        if (m_hold[m] >= 0) begin
            g[m_hold[m]] = 1'b1;
            ix           = IW'(m_hold[m]);
            v            = 1'b1;
        end
        return {g, ix, v, |req};
    endfunction

    task automatic model_step(int m);
        logic [N-1:0] c;
        if (reset) begin
            m_hold[m] = -1;
            m_last[m] = 0;
        end else if (m_hold[m] < 0) begin
            if (en && req != 0) m_hold[m] = model_pick(m, req, m_last[m]);
        end else if (done || !req[m_hold[m]]) begin
            m_last[m] = m_hold[m];
            c = req;
            c[m_hold[m]] = 1'b0;
            if (en && c != 0) m_hold[m] = model_pick(m, c, m_last[m]);
            else m_hold[m] = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        en    = 1'b1;
        done  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        en    = 1'b1;
        done  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs[m] !== expv(m)) begin
                    miscompares++;
                    $display("FAIL reset m%0d got %h want %h", m, obs[m], expv(m));
                end
            end
            vectors++;
            if ({gnt0, idx0, vld0} !== '0) begin
                miscompares++;
                $display("FAIL reset_zero got %h want 0", {gnt0, idx0, vld0});
            end
        end
        reset = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs[m] !== expv(m)) begin
                miscompares++;
                $display("FAIL reset_rel m%0d got %h want %h", m, obs[m], expv(m));
            end
        end
        vectors++;
        if (gnt1 !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_first got %b want 1000", gnt1);
        end
    endtask

    task automatic test_fixed();
        logic [N-1:0] want [3];
        want[0] = 4'b0100;
        want[1] = 4'b0010;
        want[2] = 4'b0100;
        do_reset();
        req = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            done = (c > 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs[m] !== expv(m)) begin
                    miscompares++;
                    $display("FAIL fixed m%0d got %h want %h", m, obs[m], expv(m));
                end
            end
            vectors++;
            if (gnt0 !== want[c]) begin
                miscompares++;
                $display("FAIL fixed_gnt%0d got %b want %b", c, gnt0, want[c]);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_rr();
        int seq [5];
        seq[0] = 3; seq[1] = 2; seq[2] = 1; seq[3] = 0; seq[4] = 3;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            done = (c > 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs[m] !== expv(m)) begin
                    miscompares++;
                    $display("FAIL rr m%0d got %h want %h", m, obs[m], expv(m));
                end
            end
            vectors++;
            if (vld1 !== 1'b1 || int'(idx1) != seq[c]) begin
                miscompares++;
                $display("FAIL rr_seq%0d got %0d/%b want %0d/1", c, idx1, vld1, seq[c]);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_lock();
        logic [N-1:0] rq [3];
        logic [N-1:0] want [3];
        rq[0] = 4'b0010; want[0] = 4'b0010;
        rq[1] = 4'b1010; want[1] = 4'b0010;
        rq[2] = 4'b1000; want[2] = 4'b1000;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req = rq[c];
            tick();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs[m] !== expv(m)) begin
                    miscompares++;
                    $display("FAIL lock m%0d got %h want %h", m, obs[m], expv(m));
                end
            end
            vectors++;
            if (gnt0 !== want[c] || gnt1 !== want[c]) begin
                miscompares++;
                $display("FAIL lock_gnt%0d got %b/%b want %b", c, gnt0, gnt1, want[c]);
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        en  = 1'b0;
        req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            en   = (c == 2);
            done = (c == 3);
            tick();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs[m] !== expv(m)) begin
                    miscompares++;
                    $display("FAIL enable m%0d got %h want %h", m, obs[m], expv(m));
                end
            end
            vectors++;
            if (vld0 !== (c == 2) || any0 !== 1'b1) begin
                miscompares++;
                $display("FAIL enable_vld%0d got %b/%b want %b/1", c, vld0, any0, c == 2);
            end
        end
        en   = 1'b1;
        done = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b1111;
        tick();
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs[m] !== expv(m)) begin
                miscompares++;
                $display("FAIL mid_pre m%0d got %h want %h", m, obs[m], expv(m));
            end
        end
        vectors++;
        if (idx1 !== 2'd1) begin
            miscompares++;
            $display("FAIL mid_rr got %0d want 1", idx1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({gnt1, idx1, vld1} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got %h want 0", {gnt1, idx1, vld1});
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs[m] !== expv(m)) begin
                miscompares++;
                $display("FAIL mid_post m%0d got %h want %h", m, obs[m], expv(m));
            end
        end
        vectors++;
        if (idx1 !== 2'd3) begin
            miscompares++;
            $display("FAIL mid_first got %0d want 3", idx1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req   = N'($urandom);
            en    = ($urandom_range(0, 4) != 0);
            done  = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 39) == 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs[m] !== expv(m)) begin
                    miscompares++;
                    $display("FAIL random%0d m%0d got %h want %h", c, m, obs[m], expv(m));
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_hold[0] = -1; m_hold[1] = -1;
        m_last[0] = 0;  m_last[1] = 0;
        reset = 1'b1;
        req   = '0;
        en    = 1'b0;
        done  = 1'b0;
        test_reset();
        test_fixed();
        test_rr();
        test_lock();
        test_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Registered N-way request arbiter. It succeeds the team's combinational priority encoder.
- Adds a selectable fixed-priority or round-robin policy, grant locking with an explicit release handshake, and registered one-hot and indexed grant outputs.
- Sits between N requesters (DMA channels, interrupt sources) and a single shared resource.

Parameters:
- N, 4, number of requesters; legal values are N >= 2.
- MODE, 0, arbitration policy: 0 = fixed priority (highest index wins), 1 = round-robin.
- IDX_W, $clog2(N), width of the grant index. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- en  input  1  arbitration enable; low blocks new grants only.
- done  input  1  holder releases the grant this cycle.
- gnt  output  N  registered one-hot grant.
- gnt_idx  output  IDX_W  registered index of the granted requester.
- gnt_vld  output  1  registered; a grant is active.
- any_req  output  1  combinational OR of req.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (sampled at a clk edge) forces:
  - gnt=0, gnt_idx=0, gnt_vld=0;
  - state=IDLE;
  - round-robin pointer last=0.
- Reset mid-grant drops the grant at that edge with no release handshake.
- States: IDLE and BUSY.
- IDLE:
  - If en=1 and req!=0, pick a winner.
  - At the next edge: gnt=onehot(w), gnt_idx=w, gnt_vld=1, state goes to BUSY.
  - Latency from req to gnt is 1 cycle.
  - Otherwise stay in IDLE with outputs at 0.
- BUSY:
  - The grant is locked. Higher-priority requests never preempt it.
  - Release condition: done=1, or req[gnt_idx]=0 (requester withdrew), sampled at an edge.
  - On release, set last=gnt_idx.
  - Back-to-back grants: in the same release cycle, if en=1 and the request set excluding the released requester is nonzero, grant the winner from that set at this edge. The state stays BUSY.
  - Otherwise go to IDLE with gnt=0, gnt_vld=0, gnt_idx=0.
  - The released requester is excluded for the release cycle only.
  - en=0 while BUSY does not revoke the grant. It only suppresses the back-to-back regrant.
  - done while IDLE is ignored.
- Winner selection:
  - MODE=0: the highest set index of the candidate vector.
  - MODE=1: search order last-1, last-2, ..., 0, N-1, ..., last, with wrap modulo N. This makes the last-served requester lowest priority. With last=0 the order equals fixed priority.
  - In MODE=0, last is updated but has no effect.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_vld equals |gnt.
  - gnt_idx equals the index of the set bit, or 0.

Decomposition:
- Shared package:
  - MODE_FIXED=0 and MODE_RR=1;
  - state encodings ST_IDLE and ST_BUSY;
  - an idx_w(N) helper that clamps the index width to at least 1.
- One natural sub-module: rr_pick.
  - Combinational, parameterised by N.
  - Inputs: candidate vector, last, mode.
  - Outputs: winner index and found flag.
  - Implementation: rotate by last, apply a highest-index priority encode, un-rotate.
- The top level holds the FSM, the pointer and the output registers.

Test Plan (N=4):
1. Reset: hold reset 2 cycles with req=4'b1111 and en=1 → gnt=0, gnt_idx=0, gnt_vld=0 throughout. After release, gnt=4'b1000 one cycle later.
2. Fixed priority (MODE=0): req=4'b0110, en=1 → next edge gnt=4'b0100, gnt_idx=2. Then pulse done with req held → back-to-back gnt=4'b0010, idx=1 (2 excluded). Next done → gnt=4'b0100 again.
3. Round-robin (MODE=1): req=4'b1111 held, done high every BUSY cycle → gnt_idx sequence 3,2,1,0,3 with no idle bubbles.
4. Lock and withdraw: grant idx 1 active, raise req[3] → gnt stays 4'b0010. Drop req[1] with done=0 → next edge gnt=4'b1000.
5. Enable gating: en=0 with req=4'b0001 → gnt_vld stays 0 and any_req=1. Set en=1 → gnt=4'b0001 after 1 cycle. en=0 during BUSY then done → IDLE, gnt=0.
6. Reset mid-grant (MODE=1): serve idx 2 and release, then assert reset during the next grant → next edge all outputs 0 and last=0. With req=4'b1111 after reset, the first grant is idx 3.
